convolver_complex: RTL and testbench

CONVOLVER_COMPLEX -- requirements
Module: convolver_complex

---
 rtl/convolver_complex.sv | 110 +++++++++++
 tb/tb_convolver_complex.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/convolver_complex.sv
// convolver_complex: streaming KERN_DIM x KERN_DIM fixed-point convolution with line buffers, bias and saturation
module convolver_complex #(
    parameter int BW       = 16,
    parameter int FRAC_BIT = 8,
    parameter int KERN_DIM = 5,
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 weight_write,
    input  logic [BW-1:0]        weight_data,
    input  logic                 enable,
    input  logic signed [BW-1:0] iPixel,
    output logic signed [BW-1:0] oOut,
    output logic                 oValid
);
    localparam int KS = KERN_DIM * KERN_DIM;
    localparam int AW = 2 * BW + $clog2(KS) + 2;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int WW = $clog2(KS + 1);
    localparam logic signed [AW-1:0] MAXV = AW'((64'sd1 <<< (BW - 1)) - 64'sd1);
    localparam logic signed [AW-1:0] MINV = ~MAXV;

    logic signed [BW-1:0] w    [KS];
    logic signed [BW-1:0] win  [KS];
    logic signed [BW-1:0] nwin [KS];
    logic signed [BW-1:0] lb   [KERN_DIM-1][IMG_W];
    logic signed [BW-1:0] bias;
    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic [WW-1:0]        wcnt;
    logic                 accept;
    logic                 hit;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] shifted;

    // a coefficient write takes priority over a pixel presented in the same cycle
    assign accept = enable && !weight_write;
    assign hit    = accept && row >= RW'(KERN_DIM - 1) && col >= CW'(KERN_DIM - 1);

    // window as it will look after this pixel: shift left, new column from line buffers plus the incoming pixel
    always_comb begin
        for (int r = 0; r < KERN_DIM; r++)
            for (int c = 0; c < KERN_DIM - 1; c++)
                nwin[r*KERN_DIM+c] = win[r*KERN_DIM+c+1];
        for (int r = 0; r < KERN_DIM - 1; r++)
            nwin[r*KERN_DIM+KERN_DIM-1] = lb[KERN_DIM-2-r][col];
        nwin[KS-1] = iPixel;
    end

    // full-precision multiply-accumulate with bias aligned to the product scale, then rescale
    always_comb begin
        acc = AW'(bias) <<< FRAC_BIT;
        for (int i = 0; i < KS; i++)
            acc = acc + AW'(w[i]) * AW'(nwin[i]);
        shifted = acc >>> FRAC_BIT;
    end

    // coefficient loading: KS weights in raster order, then the bias, then wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < KS; i++) w[i] <= '0;
            bias <= '0;
            wcnt <= '0;
        end else if (weight_write) begin
            if (wcnt == WW'(KS)) begin
                bias <= weight_data;
                wcnt <= '0;
            end else begin
                w[wcnt] <= weight_data;
                wcnt    <= wcnt + WW'(1);
            end
        end
    end

    // pixel acceptance: update window, push column history through the line buffers, advance position
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < KS; i++) win[i] <= '0;
            for (int j = 0; j < KERN_DIM - 1; j++)
                for (int x = 0; x < IMG_W; x++) lb[j][x] <= '0;
            col <= '0;
            row <= '0;
        end else if (accept) begin
            win <= nwin;
            lb[0][col] <= iPixel;
            for (int j = 1; j < KERN_DIM - 1; j++) lb[j][col] <= lb[j-1][col];
            if (col == CW'(IMG_W - 1)) begin
                col <= '0;
                row <= row == RW'(IMG_H - 1) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // registered, saturated result; oOut holds between results
    always_ff @(posedge clk) begin
        if (reset) begin
            oOut   <= '0;
            oValid <= 1'b0;
        end else begin
            oValid <= hit;
            if (hit)
                oOut <= shifted > MAXV ? MAXV[BW-1:0] : shifted < MINV ? MINV[BW-1:0] : shifted[BW-1:0];
        end
    end
endmodule

// File: tb/tb_convolver_complex.sv
// tb_convolver_complex: randomized scoreboard bench for convolver_complex on an 8x8 frame
module tb_convolver_complex;
    localparam int BW = 16, FB = 8, K = 5, W = 8, H = 8;

    logic clk = 1'b0;
    logic reset, weight_write, enable;
    logic [BW-1:0] weight_data;
    logic signed [BW-1:0] iPixel, oOut;
    logic oValid;

    convolver_complex #(.BW(BW), .FRAC_BIT(FB), .KERN_DIM(K), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .reset(reset), .weight_write(weight_write), .weight_data(weight_data),
        .enable(enable), .iPixel(iPixel), .oOut(oOut), .oValid(oValid)
    );

    always #5 clk = ~clk;

    int vectors = 0, errs = 0, nres = 0;
    logic [15:0] q[$];
    int wm[K*K];
    int bm, wk, prow, pcol;
    int img[H][W];
    logic [15:0] tw[K*K+1];
    logic [15:0] last_out = '0;
    logic rst_q = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // reference: plain integer convolution of the stored frame, then rescale and clamp
    function automatic logic [15:0] model(int R, int C);
        longint acc = longint'(bm) * 256;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                acc += longint'(wm[r*K+c]) * longint'(img[R-K+1+r][C-K+1+c]);
        acc = acc >>> FB;
        if (acc > 32767) return 16'h7fff;
        if (acc < -32768) return 16'h8000;
        return 16'(acc);
    endfunction

    always @(posedge clk) rst_q <= reset;

    // monitor: pop and compare on every oValid, check reset and hold behaviour otherwise
    always @(negedge clk) begin
        if (rst_q) begin
            chk("valid_in_reset", {31'b0, oValid}, 32'd0);
            chk("out_in_reset", {16'b0, oOut}, 32'd0);
            last_out = '0;
        end else if (oValid) begin
            nres++;
            if (q.size() == 0) begin
                vectors++;
                errs++;
                $display("FAIL spurious_valid: got oValid=1 oOut=%0h expected no result", oOut);
            end else begin
                chk("result", {16'b0, oOut}, {16'b0, q.pop_front()});
            end
            last_out = oOut;
        end else if (oOut !== last_out) begin
            chk("hold", {16'b0, oOut}, {16'b0, last_out});
        end
    end

    task automatic step(bit ww, logic [15:0] wd, bit en, logic [15:0] px);
        weight_write = ww; weight_data = wd; enable = en; iPixel = px;
        @(posedge clk);
        if (!reset) begin
            if (ww) begin
                if (wk < K*K) wm[wk] = int'($signed(wd)); else bm = int'($signed(wd));
                wk = wk == K*K ? 0 : wk + 1;
            end else if (en) begin
                img[prow][pcol] = int'($signed(px));
                if (prow >= K-1 && pcol >= K-1) q.push_back(model(prow, pcol));
                if (pcol == W-1) begin
                    pcol = 0;
                    prow = prow == H-1 ? 0 : prow + 1;
                end else pcol++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        reset = 1'b0;
        wk = 0; bm = 0; prow = 0; pcol = 0;
        for (int i = 0; i < K*K; i++) wm[i] = 0;
        q.delete();
    endtask

    task automatic load();
        for (int i = 0; i <= K*K; i++) step(1, tw[i], 0, 16'($urandom));
    endtask

    task automatic set_w(logic [15:0] wv, logic [15:0] bv);
        for (int i = 0; i < K*K; i++) tw[i] = wv;
        tw[K*K] = bv;
    endtask

    task automatic frame(int mode, logic [15:0] v, bit stalls, bit collide, int npix);
        int n0 = nres;
        for (int i = 0; i < npix; i++) begin
            int R = (i / W) % H;
            int C = i % W;
            logic [15:0] p = mode == 0 ? v : mode == 1 ? 16'(R*W+C) : 16'($urandom);
            if (stalls) while ($urandom_range(0, 2) == 0) step(0, 0, 0, 16'($urandom));
            if (collide && i == 30) step(1, tw[0], 1, 16'($urandom));
            step(0, 0, 1, p);
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        if (npix == W*H) chk("result_count", nres - n0, (H-K+1)*(W-K+1));
        chk("queue_drained", q.size(), 0);
    endtask

    initial begin
        weight_write = 0; weight_data = 0; enable = 0; iPixel = 0; reset = 1;
        do_reset();
        chk("reset_out", {16'b0, oOut}, 32'd0);
        chk("reset_valid", {31'b0, oValid}, 32'd0);
        set_w(16'h0100, 16'h0000); load();
        frame(0, 16'h0100, 0, 0, W*H);
        chk("ones_value", {16'b0, last_out}, 32'h1900);
        set_w(16'h0000, 16'h0000); tw[2*K+2] = 16'h0100; load();
        frame(1, 0, 0, 0, W*H);
        set_w(16'hff00, 16'hfe00); load();
        frame(0, 16'h0100, 0, 0, W*H);
        chk("neg_value", {16'b0, last_out}, 32'he500);
        set_w(16'h7fff, 16'h0000); load();
        frame(0, 16'h7fff, 0, 0, W*H);
        chk("sat_pos", {16'b0, last_out}, 32'h7fff);
        set_w(16'h8000, 16'h0000); load();
        frame(0, 16'h7fff, 0, 0, W*H);
        chk("sat_neg", {16'b0, last_out}, 32'h8000);
        for (int i = 0; i <= K*K; i++) tw[i] = 16'($urandom_range(0, 16'h03ff)) - 16'h0200;
        load();
        frame(2, 0, 0, 0, 20);
        do_reset();
        for (int i = 0; i <= K*K; i++) tw[i] = 16'($urandom);
        load();
        frame(2, 0, 0, 0, W*H);
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i <= K*K; i++) tw[i] = 16'($urandom_range(0, 16'h01ff)) - 16'h0100;
            load();
            frame(2, 0, 1, 1, W*H);
            wk = 0;
            do_reset();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
